mole_sequencer: RTL

Game-side initiator that picks which mole is up, drives the selector/LED lines consumed by the button validator, and receives the validator's one-cycle hit pulse. It schedules pseudo-random mole appearances, times each one, and counts hits and misses over a fixed-length round. It sits between the game-control logic and the validator/LED display.

---
 rtl/mole_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mole_sequencer.sv
// Whack-a-mole sequencer: schedules pseudo-random mole appearances, times each
// one, and tallies hits and misses over a fixed-length round.
module mole_sequencer #(
  parameter int         NUM_MOLES   = 5,
  parameter int         HOLD_CYCLES = 100,
  parameter int         GAP_CYCLES  = 20,
  parameter int         ROUND_LEN   = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hit,
  output logic [2:0]           selector,
  output logic [NUM_MOLES-1:0] leds,
  output logic                 mole_active,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic                 round_done
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int RW = $clog2(ROUND_LEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, SHOW = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        gap_cnt, gap_cnt_nxt;
  logic [HW-1:0]        hold_cnt, hold_cnt_nxt;
  logic [RW-1:0]        app_cnt, app_cnt_nxt, app_inc;
  logic [7:0]           lfsr;
  logic [2:0]           prev_sel, prev_sel_nxt, sel_nxt, cand;
  logic [NUM_MOLES-1:0] leds_nxt;
  logic                 active_nxt, done_nxt;
  logic [7:0]           score_nxt, misses_nxt;

  // Map a raw 3-bit draw onto a mole index that differs from the previous one.
  function automatic logic [2:0] pick(input logic [2:0] raw, input logic [2:0] prev);
    logic [2:0] c;
    c = raw;
    if (c >= 3'(NUM_MOLES)) c = c - 3'(NUM_MOLES);
    if (c == prev) c = (prev == 3'(NUM_MOLES - 1)) ? 3'd0 : prev + 3'd1;
    return c;
  endfunction

  // Saturating 8-bit increment for the hit/miss tallies.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign app_inc = app_cnt + RW'(1);
  assign cand    = pick(lfsr[2:0], prev_sel);

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, steps every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Next-state and next-output decode; every target defaults to hold.
  always_comb begin
    state_nxt    = state;
    gap_cnt_nxt  = gap_cnt;
    hold_cnt_nxt = hold_cnt;
    app_cnt_nxt  = app_cnt;
    prev_sel_nxt = prev_sel;
    sel_nxt      = selector;
    leds_nxt     = leds;
    active_nxt   = mole_active;
    score_nxt    = score;
    misses_nxt   = misses;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
          app_cnt_nxt = '0;
          score_nxt   = 8'd0;
          misses_nxt  = 8'd0;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt    = SHOW;
          hold_cnt_nxt = '0;
          sel_nxt      = cand;
          prev_sel_nxt = cand;
          leds_nxt     = {{(NUM_MOLES - 1){1'b0}}, 1'b1} << cand;
          active_nxt   = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      SHOW: begin
        if (hit || (hold_cnt == HW'(HOLD_CYCLES - 1))) begin
          if (hit) score_nxt  = sat_inc(score);
          else     misses_nxt = sat_inc(misses);
          app_cnt_nxt = app_inc;
          gap_cnt_nxt = '0;
          sel_nxt     = 3'b111;
          leds_nxt    = '0;
          active_nxt  = 1'b0;
          if (app_inc == RW'(ROUND_LEN)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      hold_cnt    <= '0;
      app_cnt     <= '0;
      prev_sel    <= 3'd0;
      selector    <= 3'b111;
      leds        <= '0;
      mole_active <= 1'b0;
      score       <= 8'd0;
      misses      <= 8'd0;
      round_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      app_cnt     <= app_cnt_nxt;
      prev_sel    <= prev_sel_nxt;
      selector    <= sel_nxt;
      leds        <= leds_nxt;
      mole_active <= active_nxt;
      score       <= score_nxt;
      misses      <= misses_nxt;
      round_done  <= done_nxt;
    end
  end

endmodule
